// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
// Registered operand issue, one settle cycle, registered result with per-requester valid.
module alu_share_arbiter #(
  parameter int N_REQ  = 2,
  parameter int N_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] req_a,
  input  logic [N_REQ*N_BITS-1:0] req_b,
  input  logic [N_REQ*3-1:0]      req_op,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_BITS-1:0]       rsp_result,
  output logic                    rsp_overflow,
  output logic                    busy,
  output logic [N_BITS-1:0]       alu_a,
  output logic [N_BITS-1:0]       alu_b,
  output logic [2:0]              alu_op,
  input  logic [N_BITS-1:0]       alu_result,
  input  logic                    alu_overflow
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, owner;
  logic [PW-1:0]   winner;
  logic            found;
  logic [N_BITS-1:0] win_a, win_b;
  logic [2:0]      win_op;

  // Rotating priority scan starting at ptr; first set bit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
        win_a  = req_a[idx*N_BITS +: N_BITS];
        win_b  = req_b[idx*N_BITS +: N_BITS];
        win_op = req_op[idx*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      owner        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner  <= winner;
          alu_a  <= win_a;
          alu_b  <= win_b;
          alu_op <= win_op;
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
        end
        RESP: ptr <= (owner == PW'(N_REQ-1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state)
      EXEC: begin
        gnt[owner] = 1'b1;
        busy       = 1'b1;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        busy             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an adder ALU stub (carry-out as overflow).
module tb_alu_share_arbiter;

  localparam int N_REQ  = 2;
  localparam int N_BITS = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*N_BITS-1:0] req_a, req_b;
  logic [N_REQ*3-1:0]      req_op;
  logic [N_REQ-1:0]        gnt, rsp_valid;
  logic [N_BITS-1:0]       rsp_result, alu_a, alu_b, alu_result;
  logic                    rsp_overflow, busy, alu_overflow;
  logic [2:0]              alu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {alu_overflow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_share_arbiter #(.N_REQ(N_REQ), .N_BITS(N_BITS)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic [1:0] g, input logic [1:0] v, input logic b);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0;
    tick(); tick();
    chk_pulses("reset", 2'b00, 2'b00, 1'b0);
    chk("reset.rsp_result", 32'(rsp_result), 32'h0);
    chk("reset.alu_a", 32'(alu_a), 32'h0);
    chk("reset.alu_op", 32'(alu_op), 32'h0);
    rst = 1'b0;

    // 1: single op
    req = 2'b01; req_a[15:0] = 16'h0012; req_b[15:0] = 16'h0034; req_op[2:0] = 3'd2;
    tick();
    chk_pulses("t1.grant", 2'b01, 2'b00, 1'b1);
    chk("t1.alu_a", 32'(alu_a), 32'h0012);
    chk("t1.alu_b", 32'(alu_b), 32'h0034);
    chk("t1.alu_op", 32'(alu_op), 32'h2);
    req = 2'b00;
    tick();
    chk_pulses("t1.resp", 2'b00, 2'b01, 1'b1);
    chk("t1.rsp_result", 32'(rsp_result), 32'h0046);
    chk("t1.rsp_overflow", 32'(rsp_overflow), 32'h0);
    tick();
    chk_pulses("t1.idle", 2'b00, 2'b00, 1'b0);
    chk("t1.hold_result", 32'(rsp_result), 32'h0046);

    // 2: contention after reset, alternating grants
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11;
    req_a[15:0] = 16'h0001; req_b[15:0] = 16'h0002;
    req_a[31:16] = 16'h0010; req_b[31:16] = 16'h0020;
    tick(); chk_pulses("t2.g0", 2'b01, 2'b00, 1'b1);
    tick(); chk_pulses("t2.r0", 2'b00, 2'b01, 1'b1); chk("t2.res0", 32'(rsp_result), 32'h0003);
    tick(); chk_pulses("t2.i0", 2'b00, 2'b00, 1'b0);
    tick(); chk_pulses("t2.g1", 2'b10, 2'b00, 1'b1);
    tick(); chk_pulses("t2.r1", 2'b00, 2'b10, 1'b1); chk("t2.res1", 32'(rsp_result), 32'h0030);
    tick();
    tick(); chk_pulses("t2.g2", 2'b01, 2'b00, 1'b1);
    tick(); tick();
    tick(); chk_pulses("t2.g3", 2'b10, 2'b00, 1'b1);
    req = 2'b00;
    tick(); tick();

    // 3: overflow
    req = 2'b01; req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'h0001;
    tick(); chk_pulses("t3.grant", 2'b01, 2'b00, 1'b1);
    req = 2'b00;
    tick(); chk_pulses("t3.resp", 2'b00, 2'b01, 1'b1);
    chk("t3.rsp_result", 32'(rsp_result), 32'h0000);
    chk("t3.rsp_overflow", 32'(rsp_overflow), 32'h1);
    tick();

    // 4: reset while in EXEC aborts the op
    req = 2'b01; req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006;
    tick(); chk_pulses("t4.grant", 2'b01, 2'b00, 1'b1);
    rst = 1'b1; req = 2'b00;
    tick();
    chk_pulses("t4.reset", 2'b00, 2'b00, 1'b0);
    chk("t4.rsp_overflow", 32'(rsp_overflow), 32'h0);
    chk("t4.alu_a", 32'(alu_a), 32'h0);
    rst = 1'b0;
    req = 2'b10; req_a[31:16] = 16'h0007; req_b[31:16] = 16'h0008;
    tick(); chk_pulses("t4.grant1", 2'b10, 2'b00, 1'b1);
    req = 2'b00;
    tick(); chk_pulses("t4.resp1", 2'b00, 2'b10, 1'b1);
    chk("t4.rsp_result", 32'(rsp_result), 32'h000F);
    tick();

    // 5: request withdrawn during EXEC still completes
    req = 2'b01; req_a[15:0] = 16'h0100; req_b[15:0] = 16'h0200;
    tick(); chk_pulses("t5.grant", 2'b01, 2'b00, 1'b1);
    req = 2'b00;
    tick(); chk_pulses("t5.resp", 2'b00, 2'b01, 1'b1);
    chk("t5.rsp_result", 32'(rsp_result), 32'h0300);
    tick(); chk_pulses("t5.idle0", 2'b00, 2'b00, 1'b0);
    tick(); chk_pulses("t5.idle1", 2'b00, 2'b00, 1'b0);

    // 6: operand change after grant is ignored
    req = 2'b01; req_a[15:0] = 16'h1000; req_b[15:0] = 16'h0234;
    tick(); chk_pulses("t6.grant", 2'b01, 2'b00, 1'b1);
    req_a[15:0] = 16'h5555; req = 2'b00;
    tick(); chk_pulses("t6.resp", 2'b00, 2'b01, 1'b1);
    chk("t6.alu_a", 32'(alu_a), 32'h1000);
    chk("t6.rsp_result", 32'(rsp_result), 32'h1234);
    tick();
    chk("t6.alu_a_hold", 32'(alu_a), 32'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
